pipe_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline (F,D,A,M,W). Owns the
//  per-stage valid bits, drives the PC and inter-stage latch write enables and
//  the anop/mnop/wnop qualifiers consumed by the forwarding unit. It arbitrates

---
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the F/D/A/M/W pipeline: per-stage valid bits,
// latch write enables, branch redirect select, HALT drain FSM and perf counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_ld,
  input  logic             br_mispred,
  input  logic             mem_busy,
  input  logic             halt_D,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             fd_we,
  output logic             da_we,
  output logic             am_we,
  output logic             mw_we,
  output logic             dnop,
  output logic             anop,
  output logic             mnop,
  output logic             wnop,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t state_r, state_s;
  logic   d_v_r, a_v_r, m_v_r, w_v_r;
  logic   d_v_s, a_v_s, m_v_s, w_v_s;
  logic   stall_ld_e_s, mis_e_s, mem_e_s, halt_e_s, freeze_s;
  logic   pc_we_s, pc_sel_br_s, fd_we_s, da_we_s, am_we_s, mw_we_s;

  // Hazard arbitration, valid-bit shifting and FSM next state.
  always_comb begin
    stall_ld_e_s = stall_ld & d_v_r;
    mis_e_s      = br_mispred & a_v_r;
    mem_e_s      = mem_busy & m_v_r;
    halt_e_s     = halt_D & d_v_r;
    pc_we_s      = 1'b0;
    pc_sel_br_s  = 1'b0;
    fd_we_s      = 1'b0;
    da_we_s      = 1'b0;
    am_we_s      = 1'b0;
    mw_we_s      = 1'b0;
    freeze_s     = 1'b0;
    d_v_s        = d_v_r;
    a_v_s        = a_v_r;
    m_v_s        = m_v_r;
    w_v_s        = w_v_r;
    state_s      = state_r;
    case (state_r)
      RUN: begin
        if (mem_e_s) begin
          mw_we_s  = 1'b1;
          w_v_s    = 1'b0;
          freeze_s = 1'b1;
        end else if (mis_e_s) begin
          // Squash D and the wrong-path fetch; A and older proceed.
          pc_we_s     = 1'b1;
          pc_sel_br_s = 1'b1;
          fd_we_s     = 1'b1;
          da_we_s     = 1'b1;
          am_we_s     = 1'b1;
          mw_we_s     = 1'b1;
          d_v_s       = 1'b0;
          a_v_s       = 1'b0;
          m_v_s       = a_v_r;
          w_v_s       = m_v_r;
        end else if (stall_ld_e_s) begin
          da_we_s  = 1'b1;
          am_we_s  = 1'b1;
          mw_we_s  = 1'b1;
          a_v_s    = 1'b0;
          m_v_s    = a_v_r;
          w_v_s    = m_v_r;
          freeze_s = 1'b1;
        end else begin
          pc_we_s = 1'b1;
          fd_we_s = 1'b1;
          da_we_s = 1'b1;
          am_we_s = 1'b1;
          mw_we_s = 1'b1;
          d_v_s   = ~halt_e_s;
          a_v_s   = d_v_r;
          m_v_s   = a_v_r;
          w_v_s   = m_v_r;
          if (halt_e_s) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
        end
      end
      DRAIN: begin
        d_v_s = 1'b0;
        if (mem_e_s) begin
          mw_we_s  = 1'b1;
          w_v_s    = 1'b0;
          freeze_s = 1'b1;
        end else begin
          da_we_s = 1'b1;
          am_we_s = 1'b1;
          mw_we_s = 1'b1;
          a_v_s   = 1'b0;
          m_v_s   = a_v_r;
          w_v_s   = m_v_r;
        end
        // HALTED once the HALT itself leaves W on this edge.
        if (!a_v_s && !m_v_s && !w_v_s) begin
          state_s = HALTED;
        end else begin
          state_s = DRAIN;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      default: begin
        state_s = RUN;
        d_v_s   = 1'b0;
        a_v_s   = 1'b0;
        m_v_s   = 1'b0;
        w_v_s   = 1'b0;
      end
    endcase
  end

  // State, valid bits and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      d_v_r      <= 1'b0;
      a_v_r      <= 1'b0;
      m_v_r      <= 1'b0;
      w_v_r      <= 1'b0;
      retire_cnt <= {CNT_W{1'b0}};
      stall_cnt  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      d_v_r   <= d_v_s;
      a_v_r   <= a_v_s;
      m_v_r   <= m_v_s;
      w_v_r   <= w_v_s;
      if (w_v_r && (state_r != HALTED)) begin
        retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retire_cnt <= retire_cnt;
      end
      if (freeze_s && (state_r != HALTED)) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

  assign pc_we     = ~reset & pc_we_s;
  assign pc_sel_br = ~reset & pc_sel_br_s;
  assign fd_we     = ~reset & fd_we_s;
  assign da_we     = ~reset & da_we_s;
  assign am_we     = ~reset & am_we_s;
  assign mw_we     = ~reset & mw_we_s;
  assign dnop      = reset | ~d_v_r;
  assign anop      = reset | ~a_v_r;
  assign mnop      = reset | ~m_v_r;
  assign wnop      = reset | ~w_v_r;
  assign halted    = ~reset & (state_r == HALTED);

endmodule
